// File: rtl/mem_mul_scheduler.sv
// Command-driven read -> multiply -> write-back sequencer for the 128x52 register file,
// sharing the memory port with one host requester via round-robin at word boundaries.
module mem_mul_scheduler #(
    parameter int ADDR_W  = 7,
    parameter int DATA_W  = 52,
    parameter int RD_LAT  = 1,
    parameter int MUL_LAT = 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic              host_req,
    input  logic              host_wr,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    output logic              mem_nce,
    output logic              mem_nwrt,
    output logic [ADDR_W-3:0] mem_ra,
    output logic [1:0]        mem_ca,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_do,
    input  logic [DATA_W-1:0] mul_out,
    output logic              busy,
    output logic              done
);

    localparam int WAIT_CYC = RD_LAT + MUL_LAT;
    localparam int WC_W     = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(WAIT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SLOT,
        S_RD,
        S_WAIT,
        S_WR,
        S_HOST
    } state_t;

    state_t              state, state_d;
    logic [ADDR_W-1:0]   base_q, base_d, len_q, len_d;
    logic [ADDR_W:0]     idx_q, idx_d, idx_inc;
    logic [WC_W-1:0]     wcnt_q, wcnt_d;
    logic                rr_host_q, rr_host_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                busy_d, ready_d, done_d, gnt_d, rvalid_d, nce_d, nwrt_d;
    logic [DATA_W-1:0]   din_d;
    logic                accept;

    assign accept     = cmd_valid && cmd_ready;
    assign idx_inc    = idx_q + 1'b1;
    assign mem_ra     = addr_q[ADDR_W-1:2];
    assign mem_ca     = addr_q[1:0];
    assign host_rdata = mem_do;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= S_IDLE;
            base_q      <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            wcnt_q      <= '0;
            rr_host_q   <= 1'b1;
            addr_q      <= '0;
            busy        <= 1'b0;
            cmd_ready   <= 1'b1;
            done        <= 1'b0;
            host_gnt    <= 1'b0;
            host_rvalid <= 1'b0;
            mem_nce     <= 1'b1;
            mem_nwrt    <= 1'b1;
            mem_din     <= '0;
        end else begin
            state       <= state_d;
            base_q      <= base_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            wcnt_q      <= wcnt_d;
            rr_host_q   <= rr_host_d;
            addr_q      <= addr_d;
            busy        <= busy_d;
            cmd_ready   <= ready_d;
            done        <= done_d;
            host_gnt    <= gnt_d;
            host_rvalid <= rvalid_d;
            mem_nce     <= nce_d;
            mem_nwrt    <= nwrt_d;
            mem_din     <= din_d;
        end
    end

    always_comb begin
        state_d   = state;
        base_d    = base_q;
        len_d     = len_q;
        idx_d     = idx_q;
        wcnt_d    = wcnt_q;
        rr_host_d = rr_host_q;
        addr_d    = addr_q;
        busy_d    = busy;
        ready_d   = cmd_ready;
        done_d    = 1'b0;
        gnt_d     = 1'b0;
        rvalid_d  = (state == S_HOST) && mem_nwrt;
        nce_d     = 1'b1;
        nwrt_d    = 1'b1;
        din_d     = mem_din;

        if (accept) begin
            base_d  = cmd_base;
            len_d   = cmd_len;
            idx_d   = '0;
            busy_d  = 1'b1;
            ready_d = 1'b0;
        end

        unique case (state)
            S_IDLE: begin
                if (accept)        state_d = S_SLOT;
                else if (host_req) state_d = S_HOST;
            end
            S_SLOT: begin
                // Pointer only moves when both parties contend for the slot
                if (host_req && (!busy || rr_host_q)) begin
                    state_d = S_HOST;
                    if (busy) rr_host_d = 1'b0;
                end else if (busy) begin
                    state_d = S_RD;
                    if (host_req) rr_host_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD: begin
                state_d = S_WAIT;
                wcnt_d  = '0;
            end
            S_WAIT: begin
                if (wcnt_q == WAIT_LAST) begin
                    state_d = S_WR;
                    din_d   = mul_out;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_WR: begin
                idx_d = idx_inc;
                if (idx_inc <= {1'b0, len_q}) begin
                    state_d = S_SLOT;
                end else begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end
            end
            S_HOST: begin
                if (busy || accept) state_d = S_SLOT;
                else if (host_req)  state_d = S_HOST;
                else                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Memory pins are registered from the state being entered
        unique case (state_d)
            S_RD: begin
                nce_d  = 1'b0;
                addr_d = base_q + idx_q[ADDR_W-1:0];
            end
            S_WR: begin
                nce_d  = 1'b0;
                nwrt_d = 1'b0;
            end
            S_HOST: begin
                nce_d  = 1'b0;
                nwrt_d = ~host_wr;
                addr_d = host_addr;
                gnt_d  = 1'b1;
                if (host_wr) din_d = host_wdata;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_mul_scheduler.sv
// Directed bench for mem_mul_scheduler with a behavioural 128x52 memory
// (1-cycle read) and a 1-cycle registered 26x26 multiplier.
module tb_mem_mul_scheduler;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready;
    logic [6:0]  cmd_base = '0, cmd_len = '0;
    logic        host_req = 1'b0, host_wr = 1'b0;
    logic [6:0]  host_addr = '0;
    logic [51:0] host_wdata = '0;
    logic        host_gnt, host_rvalid;
    logic [51:0] host_rdata;
    logic        mem_nce, mem_nwrt;
    logic [4:0]  mem_ra;
    logic [1:0]  mem_ca;
    logic [51:0] mem_din, mem_do, mul_out;
    logic        busy, done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    mem_mul_scheduler #(.ADDR_W(7), .DATA_W(52), .RD_LAT(1), .MUL_LAT(1)) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_base(cmd_base), .cmd_len(cmd_len),
        .host_req(host_req), .host_wr(host_wr), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .mem_nce(mem_nce), .mem_nwrt(mem_nwrt), .mem_ra(mem_ra), .mem_ca(mem_ca),
        .mem_din(mem_din), .mem_do(mem_do), .mul_out(mul_out),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [51:0] mem [128];
    always @(posedge clk) begin
        if (!mem_nce) begin
            if (!mem_nwrt) mem[{mem_ra, mem_ca}] <= mem_din;
            else           mem_do <= mem[{mem_ra, mem_ca}];
        end
        mul_out <= 52'(mem_do[51:26]) * 52'(mem_do[25:0]);
    end

    int          tr_n = 0;
    logic        tr_wr   [256];
    logic [6:0]  tr_addr [256];
    logic [51:0] tr_din  [256];
    always @(negedge clk) begin
        if (rstn && !mem_nce && tr_n < 256) begin
            tr_wr[tr_n]   <= !mem_nwrt;
            tr_addr[tr_n] <= {mem_ra, mem_ca};
            tr_din[tr_n]  <= mem_din;
            tr_n          <= tr_n + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {nce, nwrt, ra, ca, cmd_ready, gnt, rvalid, busy, done}
    function automatic logic [63:0] ctl_vec();
        return 64'({mem_nce, mem_nwrt, mem_ra, mem_ca, cmd_ready, host_gnt, host_rvalid, busy, done});
    endfunction
    localparam logic [63:0] RST_VEC = 64'({1'b1, 1'b1, 5'd0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});

    task automatic host_op(input logic wr, input logic [6:0] a, input logic [51:0] d,
                           output logic [51:0] rd);
        logic ok = 1'b0;
        rd = '0;
        host_req = 1'b1; host_wr = wr; host_addr = a; host_wdata = d;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (host_gnt) begin ok = 1'b1; break; end
        end
        host_req = 1'b0;
        check("host_gnt_seen", 64'(ok), 64'd1);
        check("host_issue_addr", 64'({mem_ra, mem_ca}), 64'(a));
        check("host_issue_nwrt", 64'(mem_nwrt), 64'(!wr));
        if (wr) check("host_issue_din", 64'(mem_din), 64'(d));
        else begin
            @(negedge clk);
            check("host_rvalid", 64'(host_rvalid), 64'd1);
            rd = host_rdata;
        end
    endtask

    task automatic run_cmd(input logic [6:0] b, input logic [6:0] l, output int acc);
        cmd_valid = 1'b1; cmd_base = b; cmd_len = l;
        check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        acc = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("busy_after_accept", 64'({busy, cmd_ready}), 64'b10);
    endtask

    task automatic wait_done(input int budget, output int dc);
        logic ok = 1'b0;
        dc = -1;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done) begin ok = 1'b1; dc = cyc; break; end
        end
        check("done_seen", 64'(ok), 64'd1);
    endtask

    initial begin
        int acc, dc, t0, nce_low, gcnt;
        logic [51:0] rd;
        logic [6:0]  exp_a [4];
        logic [51:0] exp_p [4];

        // Reset and idle
        #1 rstn = 1'b0;
        #2;
        check("reset_ctl", ctl_vec(), RST_VEC);
        check("reset_din", 64'(mem_din), 64'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        nce_low = 0;
        repeat (20) begin
            @(negedge clk);
            if (!mem_nce || host_gnt || busy) nce_low++;
        end
        check("idle_quiet", 64'(nce_low), 64'd0);
        check("idle_ctl", ctl_vec(), RST_VEC);

        // Single word: 3*7 = 21
        host_op(1'b1, 7'd5, {26'd3, 26'd7}, rd);
        @(negedge clk);
        t0 = tr_n;
        run_cmd(7'd5, 7'd0, acc);
        wait_done(50, dc);
        check("len0_done_lat", 64'(dc - acc), 64'd6);
        check("len0_ops", 64'(tr_n - t0), 64'd2);
        check("len0_rd", 64'({tr_wr[t0], tr_addr[t0]}), 64'({1'b0, 7'd5}));
        check("len0_wr", 64'({tr_wr[t0+1], tr_addr[t0+1]}), 64'({1'b1, 7'd5}));
        check("len0_din", 64'(tr_din[t0+1]), 64'd21);
        check("len0_idle", 64'({busy, cmd_ready}), 64'b01);

        // Wrap-around 126,127,0,1 with cmd_valid ignored while busy
        exp_a[0] = 7'd126; exp_a[1] = 7'd127; exp_a[2] = 7'd0; exp_a[3] = 7'd1;
        exp_p[0] = 52'd10; exp_p[1] = 52'd16; exp_p[2] = 52'd9; exp_p[3] = 52'd36;
        host_op(1'b1, 7'd126, {26'd2, 26'd5}, rd);
        host_op(1'b1, 7'd127, {26'd4, 26'd4}, rd);
        host_op(1'b1, 7'd0,   {26'd1, 26'd9}, rd);
        host_op(1'b1, 7'd1,   {26'd6, 26'd6}, rd);
        @(negedge clk);
        t0 = tr_n;
        run_cmd(7'd126, 7'd3, acc);
        cmd_valid = 1'b1; cmd_base = 7'd50; cmd_len = 7'd0;
        repeat (3) @(negedge clk);
        check("busy_not_ready", 64'(cmd_ready), 64'd0);
        cmd_valid = 1'b0;
        wait_done(100, dc);
        check("wrap_done_lat", 64'(dc - acc), 64'd21);
        check("wrap_ops", 64'(tr_n - t0), 64'd8);
        for (int j = 0; j < 4; j++) begin
            check("wrap_rd", 64'({tr_wr[t0+2*j], tr_addr[t0+2*j]}), 64'({1'b0, exp_a[j]}));
            check("wrap_wr", 64'({tr_wr[t0+2*j+1], tr_addr[t0+2*j+1]}), 64'({1'b1, exp_a[j]}));
            check("wrap_din", 64'(tr_din[t0+2*j+1]), 64'(exp_p[j]));
        end

        // Contested: host reads of 40 against a 4-word command at 20..23
        exp_p[0] = 52'd25; exp_p[1] = 52'd21; exp_p[2] = 52'd100; exp_p[3] = 52'd22;
        host_op(1'b1, 7'd20, {26'd5, 26'd5}, rd);
        host_op(1'b1, 7'd21, {26'd7, 26'd3}, rd);
        host_op(1'b1, 7'd22, {26'd10, 26'd10}, rd);
        host_op(1'b1, 7'd23, {26'd11, 26'd2}, rd);
        @(negedge clk);
        t0 = tr_n;
        gcnt = 0;
        cmd_valid = 1'b1; cmd_base = 7'd20; cmd_len = 7'd3;
        host_req = 1'b1; host_wr = 1'b0; host_addr = 7'd40;
        acc = cyc;
        dc = -1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            if (host_gnt) gcnt++;
            if (done) begin dc = cyc; break; end
        end
        host_req = 1'b0;
        check("arb_gnt_count", 64'(gcnt), 64'd4);
        check("arb_done_lat", 64'(dc - acc), 64'd29);
        check("arb_ops", 64'(tr_n - t0), 64'd12);
        for (int j = 0; j < 4; j++) begin
            check("arb_host", 64'({tr_wr[t0+3*j], tr_addr[t0+3*j]}), 64'({1'b0, 7'd40}));
            check("arb_rd", 64'({tr_wr[t0+3*j+1], tr_addr[t0+3*j+1]}), 64'({1'b0, 7'(20 + j)}));
            check("arb_wr", 64'({tr_wr[t0+3*j+2], tr_addr[t0+3*j+2]}), 64'({1'b1, 7'(20 + j)}));
        end
        @(negedge clk);
        for (int j = 0; j < 4; j++) begin
            host_op(1'b0, 7'(20 + j), '0, rd);
            check("arb_product", 64'(rd), 64'(exp_p[j]));
        end

        // Idle host read timing at addr 9
        host_op(1'b1, 7'd9, 52'hABCDE12345678, rd);
        @(negedge clk);
        host_req = 1'b1; host_wr = 1'b0; host_addr = 7'd9;
        @(negedge clk);
        host_req = 1'b0;
        check("idle_rd_gnt", 64'({host_gnt, host_rvalid}), 64'b10);
        @(negedge clk);
        check("idle_rd_rvalid", 64'({host_gnt, host_rvalid}), 64'b01);
        check("idle_rd_data", 64'(host_rdata), 64'h000ABCDE12345678);
        @(negedge clk);
        check("idle_rd_rvalid_end", 64'(host_rvalid), 64'd0);

        // Reset during WAIT of word 2 (addr 31)
        host_op(1'b1, 7'd31, {26'd9, 26'd9}, rd);
        @(negedge clk);
        run_cmd(7'd30, 7'd3, acc);
        t0 = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (!mem_nce && mem_nwrt && {mem_ra, mem_ca} == 7'd31) begin t0 = 1; break; end
        end
        check("rst_rd31_seen", 64'(t0), 64'd1);
        @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check("rst_async_ctl", ctl_vec(), RST_VEC);
        check("rst_async_din", 64'(mem_din), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        nce_low = 0;
        repeat (15) begin
            @(negedge clk);
            if (!mem_nce) nce_low++;
        end
        check("rst_no_wr", 64'(nce_low), 64'd0);
        check("rst_mem31", 64'(mem[31]), 64'({26'd9, 26'd9}));
        check("rst_ready", 64'({busy, cmd_ready}), 64'b01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_mul_scheduler.md
# mem_mul_scheduler

- Sequences the 128x52 register-file memory and the 26x26 CSA multiplier through a read → multiply → write-back loop over a commanded address range.
- Shares the memory port with a single host requester, arbitrating round-robin at word boundaries.
- Replaces free-running counter sequencing with a command/handshake-driven FSM.
- Drives all memory control pins from registers.

## Interface
Parameters:
- ADDR_W, 7, memory word address width ({RA[4:0], CA[1:0]})
- DATA_W, 52, memory word width; multiplier operands are DATA_W/2 each
- RD_LAT, 1, cycles from read issue to mem_do valid
- MUL_LAT, 1, cycles from mem_do valid to mul_out valid

Ports:
- clk  in  1  clock, all state on rising edge
- rstn  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high when IDLE and able to accept
- cmd_base  in  7  first word address
- cmd_len  in  7  word count minus 1 (0 → 1 word, 127 → 128 words)
- host_req  in  1  host access request; held until granted
- host_wr  in  1  1 = write, 0 = read
- host_addr  in  7  host address
- host_wdata  in  52  host write data
- host_gnt  out  1  one-cycle pulse in the host's issue cycle
- host_rvalid  out  1  one-cycle pulse, RD_LAT cycles after a host read issue
- host_rdata  out  52  equals mem_do while host_rvalid is high
- mem_nce  out  1  memory chip enable, active-low
- mem_nwrt  out  1  memory write enable, active-low
- mem_ra  out  5  row address
- mem_ca  out  2  column address
- mem_din  out  52  memory write data
- mem_do  in  52  memory read data; [51:26] feeds multiplier A, [25:0] feeds B
- mul_out  in  52  multiplier product
- busy  out  1  a command is in progress
- done  out  1  one-cycle pulse after the final write-back

## Operation
- Reset values: mem_nce=1, mem_nwrt=1, mem_ra=0, mem_ca=0, mem_din=0, cmd_ready=1, host_gnt=0, host_rvalid=0, busy=0, done=0. The FSM resets to IDLE and the round-robin pointer resets to "host first".
- States:
  - IDLE: no command active.
  - SLOT: arbitration point.
  - RD: sequencer read issue.
  - WAIT: nce=1 for RD_LAT+MUL_LAT cycles.
  - WR: write-back issue.
  - HOST: host issue.
- Command accept: a posedge with cmd_valid && cmd_ready latches base and len. On the same edge busy goes 1, cmd_ready goes 0, and the FSM enters SLOT.
- SLOT arbitration:
  - Host only: grant HOST.
  - Sequencer only: grant RD.
  - Both: grant the party not granted last, then flip the pointer.
  - Neither (busy=0): stay in IDLE.
- In IDLE, a host_req is served directly. Back-to-back host accesses sustain 1 per cycle.
- RD: mem_nce=0, mem_nwrt=1, {mem_ra, mem_ca} = (base + i) mod 128.
- WAIT: mem_nce=1, mem_nwrt=1, address held. mul_out is captured into mem_din on the last WAIT edge.
- WR: mem_nce=0, mem_nwrt=0, same address as the RD, mem_din = captured product. Then i increments.
  - If i ≤ len, go to SLOT.
  - Otherwise pulse done, and set busy=0 and cmd_ready=1 on the same edge.
- HOST:
  - mem_nce=0, mem_nwrt=~host_wr, address = host_addr, mem_din = host_wdata when writing.
  - host_gnt=1 in this cycle.
  - Return to SLOT, or to IDLE if not busy.
- Wrap-around: the address wraps 127 → 0 within a command. len=127 touches every word exactly once.
- No hazard protection. A host access to an in-flight address is ordered purely by issue order, and the host may read pre-write-back data.
- cmd_valid while busy is ignored (cmd_ready=0). host_req during RD, WAIT or WR waits until the next SLOT.
- Reset assertion mid-operation immediately forces all reset values. In-flight reads and write-backs are abandoned, with no partial write.

## Timing
- Control outputs are registered and change only after a posedge. The memory samples them on the following posedge.
- Word issue cycle t (RD):
  - mem_do valid in cycle t+RD_LAT.
  - mul_out valid in cycle t+RD_LAT+MUL_LAT, captured at the end of that cycle.
  - WR issued in cycle t+RD_LAT+MUL_LAT+1.
- With defaults, one word = 4 cycles (RD, WAIT, WAIT, WR) plus 1 SLOT cycle.
- Uncontested N-word command: accept edge → done pulse = 5N+1 cycles. Each contested host access adds 2 cycles (SLOT+HOST).
- host_rvalid is asserted in cycle t+RD_LAT for a host read issued in cycle t.
- Worst-case host grant latency while busy: RD_LAT+MUL_LAT+3 cycles.

## Test plan
- Reset, then idle: all outputs at their reset values; nce stays 1 for 20 cycles with no requests.
- Preload addr 5 = {26'd3, 26'd7} via host write; command base=5, len=0 → RD@5, WR@5 with din=21, done 6 cycles after accept, busy=0 afterwards.
- Command base=126, len=3 → RD/WR addresses 126, 127, 0, 1 in order; done at accept+21.
- Continuous host_req during a 4-word command → issues alternate host and sequencer, starting with host; host_gnt count = 4 before done; later host reads return the products.
- Host read of addr 9 while idle → host_gnt in cycle t, host_rvalid in t+1, host_rdata = stored word.
- Assert rstn low during the WAIT of word 2 → outputs return to reset values asynchronously; after release, no WR is issued and cmd_ready=1.
